// File: rtl/pong_pkg.sv
// Shared types and constants for the pong datapath blocks.
// Ball centre constants are also used by the ball block.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        GAME_OVER  = 2'd3
    } state_t;

    localparam int SCORE_W = 8;
    localparam int DIGIT_W = 4;
    localparam int BIN_W   = 7;
    localparam int BALL_X0 = 310;
    localparam int BALL_Y0 = 180;

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with synchronous clear/increment and a binary shadow.
// Holds at 99 so the shadow and the BCD value never diverge.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [SCORE_W-1:0] o_bcd,
    output logic [BIN_W-1:0]   o_bin
);

    logic [DIGIT_W-1:0] r_tens;
    logic [DIGIT_W-1:0] r_units;
    logic [BIN_W-1:0]   r_bin;
    logic               w_sat;

    assign w_sat = (r_tens == 4'd9) && (r_units == 4'd9);

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_tens  <= '0;
            r_units <= '0;
            r_bin   <= '0;
        end else if (i_inc && !w_sat) begin
            if (r_units == 4'd9) begin
                r_units <= '0;
                r_tens  <= r_tens + 4'd1;
            end else begin
                r_units <= r_units + 4'd1;
            end
            r_bin <= r_bin + 7'd1;
        end
    end

    assign o_bcd = {r_tens, r_units};
    assign o_bin = r_bin;

endmodule

// File: rtl/pong_score.sv
// Score keeper and match sequencer: counts points on rising edges of the ball's
// point flags, holds the ball during serves, and detects the winning score.
module pong_score
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 50_000_000,
    parameter int CNT_W       = $clog2(SERVE_DELAY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               point_1,
    input  logic               point_2,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic               ball_reset,
    output logic               game_over,
    output logic               winner
);

    localparam logic [BIN_W-1:0] WIN_BIN  = BIN_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_DELAY);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_p1_prev;
    logic               r_p2_prev;
    logic               r_ball_reset;
    logic               r_game_over;
    logic               r_winner;
    logic               w_winner_nxt;
    logic               w_ev1;
    logic               w_ev2;
    logic               w_clr;
    logic               w_inc1;
    logic               w_inc2;
    logic [BIN_W-1:0]   w_bin_1;
    logic [BIN_W-1:0]   w_bin_2;

    assign w_ev1 = point_1 & ~r_p1_prev;
    assign w_ev2 = point_2 & ~r_p2_prev;

    bcd_counter2 u_score_1 (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_inc (w_inc1),
        .o_bcd (score_1),
        .o_bin (w_bin_1)
    );

    bcd_counter2 u_score_2 (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_clr),
        .i_inc (w_inc2),
        .o_bcd (score_2),
        .o_bin (w_bin_2)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_winner_nxt = r_winner;
        w_clr        = 1'b0;
        w_inc1       = 1'b0;
        w_inc2       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = SERVE_WAIT;
                end
            end
            SERVE_WAIT: begin
                // Leaving on a count of 1 gives exactly SERVE_DELAY held cycles.
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = PLAY;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            PLAY: begin
                if (w_ev1 && w_ev2) begin
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = SERVE_WAIT;
                end else if (w_ev1) begin
                    w_inc1 = 1'b1;
                    if (w_bin_1 + 7'd1 == WIN_BIN) begin
                        w_winner_nxt = 1'b0;
                        w_state_nxt  = GAME_OVER;
                    end else begin
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = SERVE_WAIT;
                    end
                end else if (w_ev2) begin
                    w_inc2 = 1'b1;
                    if (w_bin_2 + 7'd1 == WIN_BIN) begin
                        w_winner_nxt = 1'b1;
                        w_state_nxt  = GAME_OVER;
                    end else begin
                        w_cnt_nxt   = CNT_LOAD;
                        w_state_nxt = SERVE_WAIT;
                    end
                end
            end
            GAME_OVER: begin
                if (start) begin
                    w_clr        = 1'b1;
                    w_winner_nxt = 1'b0;
                    w_cnt_nxt    = CNT_LOAD;
                    w_state_nxt  = SERVE_WAIT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_p1_prev    <= 1'b0;
            r_p2_prev    <= 1'b0;
            r_ball_reset <= 1'b1;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_p1_prev    <= point_1;
            r_p2_prev    <= point_2;
            r_ball_reset <= (w_state_nxt != PLAY);
            r_game_over  <= (w_state_nxt == GAME_OVER);
            r_winner     <= w_winner_nxt;
        end
    end

    assign ball_reset = r_ball_reset;
    assign game_over  = r_game_over;
    assign winner     = r_winner;

endmodule

// File: tb/tb_pong_score.sv
// Bench for pong_score with WIN_SCORE=10 and SERVE_DELAY=4.
// Expected outputs are queued from a small score model and compared when the DUT settles.
module tb_pong_score;

    localparam int WIN = 10;
    localparam int DLY = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       point_1 = 1'b0;
    logic       point_2 = 1'b0;
    logic [7:0] score_1;
    logic [7:0] score_2;
    logic       ball_reset;
    logic       game_over;
    logic       winner;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_s1 = 0;
    int          m_s2 = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    pong_score #(
        .WIN_SCORE   (WIN),
        .SERVE_DELAY (DLY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .point_1    (point_1),
        .point_2    (point_2),
        .score_1    (score_1),
        .score_2    (score_2),
        .ball_reset (ball_reset),
        .game_over  (game_over),
        .winner     (winner)
    );

    function automatic logic [7:0] bcd(input int n);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    function automatic void push_exp(input logic go, input logic w);
        exp_q.push_back({bcd(m_s1), bcd(m_s2), go, w});
    endfunction

    // Drive point flags for 'hold' cycles, then count ball_reset-high samples until PLAY resumes.
    task automatic point(input logic a, input logic b, input int hold, output int hi);
        hi = 0;
        point_1 = a;
        point_2 = b;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ball_reset) hi++;
        end
        point_1 = 1'b0;
        point_2 = 1'b0;
        for (int i = 0; i < 30 && ball_reset && !game_over; i++) begin
            @(negedge clk);
            if (ball_reset) hi++;
        end
    endtask

    task automatic test_reset();
        logic [17:0] e;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_exp(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", {score_1, score_2, game_over, winner}, e);
        end
        n_tests++;
        if (ball_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ball_reset: got %b expected 1", ball_reset);
        end
    endtask

    task automatic test_serve();
        logic [17:0] e;
        int hi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_s1 = 0;
        m_s2 = 0;
        push_exp(1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e) begin
            n_fail++;
            $display("FAIL serve_outputs: got %h expected %h", {score_1, score_2, game_over, winner}, e);
        end
        hi = ball_reset ? 1 : 0;
        for (int i = 0; i < 30 && ball_reset; i++) begin
            @(negedge clk);
            if (ball_reset) hi++;
        end
        n_tests++;
        if (hi !== DLY) begin
            n_fail++;
            $display("FAIL serve_hold: got %0d cycles expected %0d", hi, DLY);
        end
    endtask

    task automatic test_point_hold();
        logic [17:0] e;
        int hi;
        m_s1++;
        push_exp(1'b0, 1'b0);
        point(1'b1, 1'b0, 3, hi);
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e) begin
            n_fail++;
            $display("FAIL hold_outputs: got %h expected %h", {score_1, score_2, game_over, winner}, e);
        end
        n_tests++;
        if (hi !== DLY) begin
            n_fail++;
            $display("FAIL hold_serve: got %0d cycles expected %0d", hi, DLY);
        end
        n_tests++;
        if (ball_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_play: ball_reset got %b expected 0", ball_reset);
        end
    endtask

    task automatic test_let();
        logic [17:0] e;
        int hi;
        push_exp(1'b0, 1'b0);
        point(1'b1, 1'b1, 1, hi);
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e) begin
            n_fail++;
            $display("FAIL let_outputs: got %h expected %h", {score_1, score_2, game_over, winner}, e);
        end
        n_tests++;
        if (hi !== DLY) begin
            n_fail++;
            $display("FAIL let_serve: got %0d cycles expected %0d", hi, DLY);
        end
    endtask

    task automatic test_start_in_play();
        logic [17:0] e;
        int hi;
        hi = 0;
        push_exp(1'b0, 1'b0);
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (ball_reset) hi++;
        end
        start = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e || hi != 0) begin
            n_fail++;
            $display("FAIL start_in_play: got %h br_hi=%0d expected %h br_hi=0",
                     {score_1, score_2, game_over, winner}, hi, e);
        end
    endtask

    task automatic test_p2_to_win();
        logic [17:0] e;
        logic go;
        int hi;
        for (int k = 1; k <= WIN; k++) begin
            m_s2++;
            go = (m_s2 == WIN);
            push_exp(go, go);
            point(1'b0, 1'b1, 1, hi);
            e = exp_q.pop_front();
            n_tests++;
            if ({score_1, score_2, game_over, winner} !== e) begin
                n_fail++;
                $display("FAIL p2_point_%0d: got %h expected %h", k,
                         {score_1, score_2, game_over, winner}, e);
            end
            n_tests++;
            if (go ? (ball_reset !== 1'b1) : (hi != DLY)) begin
                n_fail++;
                $display("FAIL p2_serve_%0d: got ball_reset=%b hi=%0d expected %s", k,
                         ball_reset, hi, go ? "ball_reset=1" : "hi=4");
            end
        end
    endtask

    task automatic test_game_over();
        logic [17:0] e;
        int hi;
        push_exp(1'b1, 1'b1);
        point(1'b1, 1'b0, 1, hi);
        repeat (3) @(negedge clk);
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e || ball_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL over_frozen: got %h br=%b expected %h br=1",
                     {score_1, score_2, game_over, winner}, ball_reset, e);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_s1 = 0;
        m_s2 = 0;
        push_exp(1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e) begin
            n_fail++;
            $display("FAIL restart_outputs: got %h expected %h", {score_1, score_2, game_over, winner}, e);
        end
        hi = ball_reset ? 1 : 0;
        for (int i = 0; i < 30 && ball_reset; i++) begin
            @(negedge clk);
            if (ball_reset) hi++;
        end
        n_tests++;
        if (hi !== DLY) begin
            n_fail++;
            $display("FAIL restart_serve: got %0d cycles expected %0d", hi, DLY);
        end
    endtask

    task automatic test_reset_mid_serve();
        logic [17:0] e;
        int hi;
        m_s1++;
        push_exp(1'b0, 1'b0);
        point_1 = 1'b1;
        @(negedge clk);
        point_1 = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e || ball_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got %h br=%b expected %h br=1",
                     {score_1, score_2, game_over, winner}, ball_reset, e);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        point_2 = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        point_2 = 1'b0;
        m_s1 = 0;
        m_s2 = 0;
        push_exp(1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if ({score_1, score_2, game_over, winner} !== e || ball_reset !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got %h br=%b expected %h br=1",
                     {score_1, score_2, game_over, winner}, ball_reset, e);
        end
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (ball_reset) hi++;
        end
        n_tests++;
        if (hi != 10) begin
            n_fail++;
            $display("FAIL idle_hold: ball_reset high %0d of 10 cycles expected 10", hi);
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_point_hold();
        test_let();
        test_start_in_play();
        test_p2_to_win();
        test_game_over();
        test_reset_mid_serve();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
